// File: rtl/ext_bus_sequencer.sv
// ext_bus_sequencer: carries one core memory request over a narrow,
// time-multiplexed pin interface. The address goes out in A beats on pin_addr,
// a control beat follows on the data pins, then D data beats are sent or
// received, with ext_rdy stretching each data beat. Pin outputs are decoded
// from the state register only, so an asynchronous reset releases them at once.
module ext_bus_sequencer #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int PIN_W      = 8,
  parameter int WAIT_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [PIN_W-1:0]  pin_addr,
  output logic              pin_ale,
  output logic              pin_sync,
  output logic [PIN_W-1:0]  pin_data_out,
  output logic [PIN_W-1:0]  pin_data_oe,
  input  logic [PIN_W-1:0]  pin_data_in,
  input  logic              ext_rdy
);

  localparam int A      = ADDR_W / PIN_W;
  localparam int D      = DATA_W / PIN_W;
  localparam int MAXB   = (A > D) ? A : D;
  localparam int BEAT_W = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, CTRL, DATA, RESP} state_e;

  state_e             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               rw_q, rw_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [DATA_W-1:0]  accShift;

  // State and datapath registers; reset returns to IDLE with everything cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      wait_q  <= '0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      acc_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      rw_q    <= rw_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      acc_q   <= acc_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic plus pin decode. The address and write data are kept in
  // shift registers so the most significant beat is always at the top; read
  // beats shift in from the bottom, which also assembles them MSB first.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    wait_d       = wait_q;
    rw_d         = rw_q;
    err_d        = err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    acc_d        = acc_q;
    rdata_d      = rdata_q;
    accShift     = (acc_q << PIN_W) | DATA_W'(pin_data_in);
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_err      = 1'b0;
    pin_addr     = '0;
    pin_ale      = 1'b0;
    pin_sync     = 1'b0;
    pin_data_out = '0;
    pin_data_oe  = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          rw_d    = req_rw;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          acc_d   = '0;
          beat_d  = '0;
          wait_d  = '0;
          err_d   = 1'b0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        pin_addr = addr_q[ADDR_W-1 -: PIN_W];
        pin_ale  = 1'b1;
        pin_sync = (beat_q == '0);
        addr_d   = addr_q << PIN_W;
        if (beat_q == BEAT_W'(A - 1)) begin
          beat_d  = '0;
          state_d = CTRL;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      CTRL: begin
        pin_data_out = PIN_W'(rw_q);
        pin_data_oe  = '1;
        state_d      = DATA;
      end
      DATA: begin
        if (!rw_q) begin
          pin_data_out = wdata_q[DATA_W-1 -: PIN_W];
          pin_data_oe  = '1;
        end
        if (ext_rdy) begin
          wait_d = '0;
          if (rw_q) begin
            acc_d = accShift;
          end else begin
            wdata_d = wdata_q << PIN_W;
          end
          if (beat_q == BEAT_W'(D - 1)) begin
            beat_d  = '0;
            rdata_d = rw_q ? accShift : '0;
            state_d = RESP;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else if (WAIT_LIMIT != 0 && int'(wait_q) + 1 >= WAIT_LIMIT) begin
          wait_d  = '0;
          beat_d  = '0;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else if (wait_q != '1) begin
          wait_d = wait_q + 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_ext_bus_sequencer.sv
// Testbench for ext_bus_sequencer. Two instances share clock and reset: one at
// the default widths, one with 24-bit address, 16-bit data and WAIT_LIMIT = 4.
// A select picks which instance the stimulus and observation apply to.
module tb_ext_bus_sequencer;

  typedef struct packed {
    logic       ready;
    logic       rv;
    logic       re;
    logic [7:0] addr;
    logic       ale;
    logic       sync;
    logic [7:0] dout;
    logic [7:0] oe;
  } pinsT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        reqValid, reqRw, extRdy;
  logic [23:0] reqAddr;
  logic [15:0] reqWdata;
  logic [7:0]  dataIn;

  logic       dReqValid, dReady, dRv, dRe, dAle, dSync;
  logic [7:0] dRdata, dAddr, dDout, dOe;
  logic        mReqValid, mReady, mRv, mRe, mAle, mSync;
  logic [15:0] mRdata;
  logic [7:0]  mAddr, mDout, mOe;

  assign dReqValid = reqValid & ~sel;
  assign mReqValid = reqValid & sel;

  ext_bus_sequencer #(.ADDR_W(16), .DATA_W(8), .PIN_W(8), .WAIT_LIMIT(15)) dutDef (
    .clk(clk), .rst_n(rst_n), .req_valid(dReqValid), .req_ready(dReady),
    .req_rw(reqRw), .req_addr(reqAddr[15:0]), .req_wdata(reqWdata[7:0]),
    .rsp_valid(dRv), .rsp_err(dRe), .rsp_rdata(dRdata), .pin_addr(dAddr),
    .pin_ale(dAle), .pin_sync(dSync), .pin_data_out(dDout), .pin_data_oe(dOe),
    .pin_data_in(dataIn), .ext_rdy(extRdy)
  );

  ext_bus_sequencer #(.ADDR_W(24), .DATA_W(16), .PIN_W(8), .WAIT_LIMIT(4)) dutMulti (
    .clk(clk), .rst_n(rst_n), .req_valid(mReqValid), .req_ready(mReady),
    .req_rw(reqRw), .req_addr(reqAddr), .req_wdata(reqWdata),
    .rsp_valid(mRv), .rsp_err(mRe), .rsp_rdata(mRdata), .pin_addr(mAddr),
    .pin_ale(mAle), .pin_sync(mSync), .pin_data_out(mDout), .pin_data_oe(mOe),
    .pin_data_in(dataIn), .ext_rdy(extRdy)
  );

  pinsT        obs;
  logic [15:0] obsRdata;
  assign obs = sel ? {mReady, mRv, mRe, mAddr, mAle, mSync, mDout, mOe}
                   : {dReady, dRv, dRe, dAddr, dAle, dSync, dDout, dOe};
  assign obsRdata = sel ? mRdata : {8'h00, dRdata};

  int          nChecks = 0;
  int          nFails  = 0;
  int          waitCfg [2];
  logic [15:0] lastRdata [2];

  // Builds the expected cycle-by-cycle pin picture of one transfer from the
  // bus protocol rules, then drives it starting with the accept cycle.
  task automatic runXfer(input string name, input bit rw, input logic [23:0] addr,
                         input logic [15:0] wdata, input logic [15:0] rdval);
    pinsT        sched [64];
    logic        rdyS [64];
    logic [7:0]  dinS [64];
    int          n, nA, nD, limit, low;
    bit          abort;
    logic [7:0]  wb, rb;
    logic [15:0] expData, expR, mask;
    nA = sel ? 3 : 2;
    nD = sel ? 2 : 1;
    limit = sel ? 4 : 15;
    mask = sel ? 16'hFFFF : 16'h00FF;
    sched[0] = '0;
    sched[0].ready = 1'b1;
    rdyS[0] = 1'($urandom);
    dinS[0] = 8'($urandom);
    n = 1;
    for (int i = 0; i < nA; i++) begin
      sched[n] = '0;
      sched[n].addr = 8'(addr >> (8 * (nA - 1 - i)));
      sched[n].ale = 1'b1;
      sched[n].sync = (i == 0);
      rdyS[n] = 1'($urandom);
      dinS[n] = 8'($urandom);
      n++;
    end
    sched[n] = '0;
    sched[n].dout = {7'b0, rw};
    sched[n].oe = 8'hFF;
    rdyS[n] = 1'($urandom);
    dinS[n] = 8'($urandom);
    n++;
    abort = 1'b0;
    for (int j = 0; j < nD; j++) begin
      if (!abort) begin
        wb = 8'(wdata >> (8 * (nD - 1 - j)));
        rb = 8'(rdval >> (8 * (nD - 1 - j)));
        low = waitCfg[j];
        if (limit != 0 && low >= limit) begin
          low = limit;
          abort = 1'b1;
        end
        for (int k = 0; k < low; k++) begin
          sched[n] = '0;
          sched[n].dout = rw ? 8'h00 : wb;
          sched[n].oe = rw ? 8'h00 : 8'hFF;
          rdyS[n] = 1'b0;
          dinS[n] = 8'($urandom);
          n++;
        end
        if (!abort) begin
          sched[n] = '0;
          sched[n].dout = rw ? 8'h00 : wb;
          sched[n].oe = rw ? 8'h00 : 8'hFF;
          rdyS[n] = 1'b1;
          dinS[n] = rw ? rb : 8'($urandom);
          n++;
        end
      end
    end
    sched[n] = '0;
    sched[n].rv = 1'b1;
    sched[n].re = abort;
    rdyS[n] = 1'($urandom);
    dinS[n] = 8'($urandom);
    n++;
    expData = (rw && !abort) ? (rdval & mask) : 16'h0000;

    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      extRdy = rdyS[c];
      dataIn = dinS[c];
      if (c == 0) begin
        reqValid = 1'b1;
        reqRw = rw;
        reqAddr = addr;
        reqWdata = wdata;
      end else begin
        reqValid = (c == n - 1) ? 1'b0 : 1'($urandom);
        reqRw = 1'($urandom);
        reqAddr = 24'($urandom);
        reqWdata = 16'($urandom);
      end
      nChecks++;
      if (obs !== sched[c]) begin
        nFails++;
        $display("[TB] FAIL %s pins cycle %0d: got %h want %h", name, c, obs, sched[c]);
      end
      expR = sched[c].rv ? expData : lastRdata[sel];
      nChecks++;
      if (obsRdata !== expR) begin
        nFails++;
        $display("[TB] FAIL %s rdata cycle %0d: got %h want %h", name, c, obsRdata, expR);
      end
      if (sched[c].rv) lastRdata[sel] = expData;
    end
  endtask

  // Reset state of both instances, then release.
  task automatic test_reset();
    pinsT idle;
    idle = '0;
    idle.ready = 1'b1;
    rst_n = 1'b0;
    reqValid = 1'b0; reqRw = 1'b0; reqAddr = '0; reqWdata = '0;
    extRdy = 1'b1; dataIn = '0;
    waitCfg[0] = 0; waitCfg[1] = 0;
    lastRdata[0] = '0; lastRdata[1] = '0;
    sel = 1'b0;
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      nChecks++;
      if (obs !== idle || obsRdata !== 16'h0) begin
        nFails++;
        $display("[TB] FAIL reset inst %0d: got %h/%h want %h/0000", s, obs, obsRdata, idle);
      end
    end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reads and writes at default widths, including the example transfers.
  task automatic test_basic();
    sel = 1'b0;
    runXfer("read_beef", 1'b1, 24'h00BEEF, 16'h0000, 16'h005A);
    runXfer("write_1234", 1'b0, 24'h001234, 16'h00C3, 16'h0000);
  endtask

  // Wait states stretch a data beat by one cycle each.
  task automatic test_wait_states();
    sel = 1'b0;
    waitCfg[0] = 3;
    runXfer("wait3_read", 1'b1, 24'h004321, 16'h0000, 16'h0096);
    waitCfg[0] = 14;
    runXfer("wait14_write", 1'b0, 24'h00ABCD, 16'h0071, 16'h0000);
    waitCfg[0] = 0;
  endtask

  // Timeout abort at the limit, and transfers just under it.
  task automatic test_timeout();
    sel = 1'b1;
    waitCfg[0] = 100; waitCfg[1] = 0;
    runXfer("timeout_m", 1'b1, 24'h0F0F0F, 16'h0000, 16'h1234);
    waitCfg[0] = 3; waitCfg[1] = 3;
    runXfer("under_limit_m", 1'b1, 24'h111111, 16'h0000, 16'h8421);
    waitCfg[0] = 0; waitCfg[1] = 4;
    runXfer("timeout_beat1_m", 1'b0, 24'h222222, 16'hBEAD, 16'h0000);
    sel = 1'b0;
    waitCfg[0] = 15; waitCfg[1] = 0;
    runXfer("timeout_def", 1'b1, 24'h003333, 16'h0000, 16'h00EE);
    waitCfg[0] = 0;
    waitCfg[1] = 0;
  endtask

  // Multi-beat address and data.
  task automatic test_multi_beat();
    sel = 1'b1;
    runXfer("multi_read", 1'b1, 24'h123456, 16'h0000, 16'hA1B2);
    runXfer("multi_write", 1'b0, 24'hFEDCBA, 16'h5AA5, 16'h0000);
  endtask

  // Random transfers issued back to back on randomly chosen instances.
  task automatic test_back_to_back();
    for (int t = 0; t < 24; t++) begin
      sel = 1'($urandom);
      waitCfg[0] = $urandom_range(0, 5);
      waitCfg[1] = $urandom_range(0, 5);
      runXfer("random", 1'($urandom), 24'($urandom), 16'($urandom), 16'($urandom));
    end
    waitCfg[0] = 0;
    waitCfg[1] = 0;
  endtask

  // Reset in the data cycle of a write, then a normal read afterwards.
  task automatic test_reset_mid();
    bit sawRv;
    sel = 1'b0;
    @(negedge clk);
    extRdy = 1'b1;
    reqValid = 1'b1; reqRw = 1'b0; reqAddr = 24'h001234; reqWdata = 16'h00C3;
    @(negedge clk);
    reqValid = 1'b0;
    repeat (3) @(negedge clk);
    nChecks++;
    if (obs.oe !== 8'hFF || obs.dout !== 8'hC3) begin
      nFails++;
      $display("[TB] FAIL reset_mid data beat: got oe %h dout %h want ff c3", obs.oe, obs.dout);
    end
    #1 rst_n = 1'b0;
    #1;
    nChecks++;
    if (obs.oe !== 8'h00 || obs.dout !== 8'h00 || obs.ready !== 1'b1 || obs.rv !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_mid async release: got %h want oe/dout 0, ready 1", obs);
    end
    sawRv = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (dRv !== 1'b0 || mRv !== 1'b0) sawRv = 1'b1;
    end
    nChecks++;
    if (sawRv) begin
      nFails++;
      $display("[TB] FAIL reset_mid rsp_valid in reset: got 1 want 0");
    end
    rst_n = 1'b1;
    lastRdata[0] = '0;
    lastRdata[1] = '0;
    runXfer("after_reset", 1'b1, 24'h00C0DE, 16'h0000, 16'h003C);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_timeout();
    test_multi_beat();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
